seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised multiplexed seven-segment scan controller for the UART receive path. It captures bytes from the receiver's `rx_valid`/`rx_data` handshake into a scrolling nibble history buffer. It time-multiplexes that history onto `NUM_DIGITS` common-anode digits with a configurable blank (anti-ghost) gap and dwell per digit. It sits between the UART receiver and the board's hex-to-segment decoder and anode pins, and runs on the divided display clock `clkdv`.

## Interface
- `NUM_DIGITS`, 4: digits scanned; even, ≥2; buffer holds `NUM_DIGITS/2` bytes.
- `BLANK`, 2: cycles per slot with all anodes off before the digit lights; ≥1.
- `DWELL`, 2: cycles per slot with the selected anode on; ≥1.
- `LZ_BLANK`, 0: 1 suppresses leading zero digits; digit 0 is never suppressed.
- `clkdv`, in, 1: display clock.
- `reset`, in, 1: asynchronous, active-high.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`, in, 8: received byte.
- `hold`, in, 1: 1 ignores `rx_valid`, freezing the buffer.
- `clear`, in, 1: synchronous buffer clear.
- `an`, out, `NUM_DIGITS`: active-low anodes; bit i drives digit i (MSD = `NUM_DIGITS-1`).
- `out`, out, 4: nibble for the currently selected digit, to the segment decoder.
- `digit_sel`, out, `max(1,$clog2(NUM_DIGITS))`: index of the current slot's digit.
- `frame_start`, out, 1: one-cycle pulse on the first cycle of the digit `NUM_DIGITS-1` slot.

## Operation
- Reset values, all asynchronous: `an` all ones, `out`=0, `digit_sel`=`NUM_DIGITS-1`, `frame_start`=0, buffer=0, slot timer=0, suppress flag=0.
- Buffer: `NUM_DIGITS*4` bits; nibble i feeds digit i.
- On `rx_valid`=1 and `hold`=0, shift the buffer left 8 bits and load `rx_data` into nibbles 1:0. The high nibble goes to digit 1, the low nibble to digit 0, and older bytes move toward the MSD. The oldest byte is discarded.
- Every asserted strobe is captured regardless of scan phase; no strobe is lost.
- `clear`=1 zeroes the buffer. With `clear` and `rx_valid` in the same cycle, `clear` wins and the byte is dropped. `hold` does not block `clear`.
- Scan order: `NUM_DIGITS-1` down to 0, then wrap to `NUM_DIGITS-1`.
- Each slot is `BLANK+DWELL` cycles, with phases BLANK then ON.
- Slot first cycle:
  - `digit_sel` takes the new index.
  - `out` takes that buffer nibble, sampled before any same-edge buffer update.
  - `an` goes all ones.
  - The suppress flag is computed.
- `out` is held for the entire slot; buffer changes mid-slot do not appear until that digit's next slot.
- Suppress flag: set when `LZ_BLANK`=1, digit index ≠ 0, and every nibble from index through `NUM_DIGITS-1` is 0, using the same snapshot. It is always 0 when `LZ_BLANK`=0.
- ON phase: `an[digit_sel]`=0 unless suppressed; all other bits stay 1.
- At most one anode is low in any cycle; `an` is never low during BLANK.
- Slot timer counts 0..`BLANK+DWELL-1` and then wraps. Its width is sized from the parameter sum, with no overflow for any legal value.

## Timing
- All outputs are registered on `posedge clkdv`.
- Relative to slot start edge k:
  - `an` bit falls at edge k+`BLANK`.
  - `an` bit rises at edge k+`BLANK`+`DWELL`, which is the next slot start.
- Frame period is `NUM_DIGITS*(BLANK+DWELL)` cycles; `frame_start` repeats at exactly that period.
- First clkdv edge after reset deassertion starts slot `NUM_DIGITS-1`. On that edge `frame_start`=1 and `out` takes nibble `NUM_DIGITS-1`.
- Capture latency: a byte strobed at edge e is visible in the buffer after edge e. It reaches `out` at the first slot start of digit 1 or 0 after edge e.
- Reset mid-slot: `an` goes all ones immediately and the buffer is lost; no partial slot completes.
- Back-to-back `rx_valid` on consecutive cycles: each byte shifts in turn.

## Test plan
Defaults for all scenarios: `NUM_DIGITS`=4, `BLANK`=2, `DWELL`=2, `LZ_BLANK`=0.
- Reset then free run, no data: `an` sequence per 4-cycle slot is `1111,1111,0111,0111`, then the same pattern for digits 2,1,0. `frame_start` fires every 16 cycles; `out`=0 throughout.
- Send 0x3C: digit 1 shows 3 and digit 0 shows C. Then send 0xA5: digits 3..0 show A,5 becoming 3,C,A,5 respectively, i.e. order 3,C,A,5.
- Send 0x7E mid-ON phase of digit 1: `out` stays at its old value until that slot ends. The next digit 1 slot shows 7 and the next digit 0 slot shows E.
- `clear` and `rx_valid` (0xFF) in the same cycle: buffer becomes 0 and all digits show 0. With `hold`=1, send 0x12: buffer unchanged.
- `LZ_BLANK`=1, buffer 0x0005: `an[3]`, `an[2]` and `an[1]` stay 1 in their slots and `an[0]` pulses low. With buffer 0x0000, only digit 0 lights, showing 0.
- `NUM_DIGITS`=8, `BLANK`=1, `DWELL`=3: frame is 32 cycles; four bytes 11,22,33,44 display as 1,1,2,2,3,3,4,4 from digit 7 down to digit 0. Assert reset mid-frame: `an`=all ones immediately and the scan restarts at digit 7.

Source files
------------

// File: rtl/seg_scan_display_if.sv
// rtl/seg_scan_display_if.sv - receive-path and display bus for seg_scan_display
//
// Purpose: groups the UART byte handshake and the scan outputs so the scan
// controller exposes a single bus port beside its clock and reset.
// Signals:
//   rx_valid    one-cycle strobe, rx_data valid this cycle   (master -> slave)
//   rx_data     received byte                                (master -> slave)
//   hold        1 freezes the history buffer against strobes (master -> slave)
//   clear       synchronous history buffer clear             (master -> slave)
//   an          active-low anodes, bit i drives digit i      (slave -> master)
//   out         nibble for the selected digit                (slave -> master)
//   digit_sel   index of the digit in the current slot       (slave -> master)
//   frame_start pulse on first cycle of the MSD slot         (slave -> master)

interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  hold;
    logic                  clear;
    logic [NUM_DIGITS-1:0] an;
    logic [3:0]            out;
    logic [SEL_W-1:0]      digit_sel;
    logic                  frame_start;

    modport master (
        output rx_valid, rx_data, hold, clear,
        input  an, out, digit_sel, frame_start
    );

    modport slave (
        input  rx_valid, rx_data, hold, clear,
        output an, out, digit_sel, frame_start
    );
endinterface

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed seven-segment scan controller for received bytes
//
// Purpose: captures received bytes into a scrolling nibble history and scans
// that history onto NUM_DIGITS common-anode digits, each slot being BLANK
// cycles with all anodes off followed by DWELL cycles with one anode on.
// Ports:
//   clkdv  divided display clock
//   reset  asynchronous, active-high
//   bus    seg_scan_display_if.slave (rx_valid, rx_data, hold, clear in;
//          an, out, digit_sel, frame_start out)

module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int BLANK      = 2,
    parameter int DWELL      = 2,
    parameter int LZ_BLANK   = 0
) (
    input  logic             clkdv,
    input  logic             reset,
    seg_scan_display_if.slave bus
);
    localparam int SLOT = BLANK + DWELL;
    // SLOT is at least 2, so this is at least one bit and holds SLOT-1.
    localparam int CW   = $clog2(SLOT);
    localparam int BW   = NUM_DIGITS * 4;
    localparam int SW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SW-1:0] LAST_DIG  = SW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);
    localparam logic [CW-1:0] SLOT_END  = CW'(SLOT - 1);

    // ST_IDLE only exists between reset release and the first edge, so the
    // first edge after reset always opens the MSD slot.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         timer_q, timer_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [3:0]            out_q, out_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;
    logic                  sup_q, sup_d;
    logic [BW-1:0]         buf_q, buf_d;

    logic [SW-1:0]         next_sel;
    logic [3:0]            next_nib;
    logic                  next_sup;
    logic [NUM_DIGITS-1:0] an_lit;
    logic                  slot_start;

    // Snapshot for the slot that would start on this edge. It reads buf_q,
    // i.e. the buffer before any capture happening on the same edge.
    always_comb begin
        next_sel = (state_q == ST_IDLE || sel_q == '0) ? LAST_DIG : (sel_q - SW'(1));
        next_nib = 4'h0;
        next_sup = (LZ_BLANK != 0) && (next_sel != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (SW'(i) == next_sel) begin
                next_nib = buf_q[i*4 +: 4];
            end
            // Any non-zero nibble at or above the digit means it is significant.
            if (SW'(i) >= next_sel && buf_q[i*4 +: 4] != 4'h0) begin
                next_sup = 1'b0;
            end
        end
    end

    // Anode pattern for the ON phase of the current slot: only the selected
    // digit is driven low.
    always_comb begin
        an_lit = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (SW'(i) == sel_q) begin
                an_lit[i] = 1'b0;
            end
        end
    end

    // Scan FSM next-state and registered-output values.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + CW'(1);
        sel_d      = sel_q;
        out_d      = out_q;
        an_d       = an_q;
        fs_d       = 1'b0;
        sup_d      = sup_q;
        slot_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                slot_start = 1'b1;
            end
            ST_BLANK: begin
                if (timer_q == BLANK_END) begin
                    state_d = ST_ON;
                    an_d    = sup_q ? '1 : an_lit;
                end
            end
            ST_ON: begin
                if (timer_q == SLOT_END) begin
                    slot_start = 1'b1;
                end
            end
            default: begin
                slot_start = 1'b1;
            end
        endcase

        if (slot_start) begin
            state_d = ST_BLANK;
            timer_d = '0;
            sel_d   = next_sel;
            out_d   = next_nib;
            an_d    = '1;
            fs_d    = (next_sel == LAST_DIG);
            sup_d   = next_sup;
        end
    end

    // History buffer: clear beats a same-cycle strobe; hold only blocks strobes.
    always_comb begin
        buf_d = buf_q;
        if (bus.clear) begin
            buf_d = '0;
        end else if (bus.rx_valid && !bus.hold) begin
            buf_d      = buf_q << 8;
            buf_d[7:0] = bus.rx_data;
        end
    end

    always_ff @(posedge clkdv or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            sel_q   <= LAST_DIG;
            out_q   <= 4'h0;
            an_q    <= '1;
            fs_q    <= 1'b0;
            sup_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            an_q    <= an_d;
            fs_q    <= fs_d;
            sup_q   <= sup_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.out         = out_q;
    assign bus.digit_sel   = sel_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display in three configurations

module tb_seg_scan_display;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configurations: 0 = defaults, 1 = leading-zero blanking, 2 = 8 digits 1/3.
    int n_c  [3] = '{4, 4, 8};
    int bl_c [3] = '{2, 2, 1};
    int dw_c [3] = '{2, 2, 3};
    int lz_c [3] = '{0, 1, 0};

    logic       rst_v      [3];
    logic       rx_valid_v [3];
    logic [7:0] rx_data_v  [3];
    logic       hold_v     [3];
    logic       clear_v    [3];
    logic [7:0] an_w       [3];
    logic [3:0] out_w      [3];
    logic [2:0] dsel_w     [3];
    logic       fs_w       [3];

    seg_scan_display_if #(.NUM_DIGITS(4)) if0 ();
    seg_scan_display_if #(.NUM_DIGITS(4)) if1 ();
    seg_scan_display_if #(.NUM_DIGITS(8)) if2 ();

    seg_scan_display #(.NUM_DIGITS(4), .BLANK(2), .DWELL(2), .LZ_BLANK(0))
        dut0 (.clkdv(clk), .reset(rst_v[0]), .bus(if0));
    seg_scan_display #(.NUM_DIGITS(4), .BLANK(2), .DWELL(2), .LZ_BLANK(1))
        dut1 (.clkdv(clk), .reset(rst_v[1]), .bus(if1));
    seg_scan_display #(.NUM_DIGITS(8), .BLANK(1), .DWELL(3), .LZ_BLANK(0))
        dut2 (.clkdv(clk), .reset(rst_v[2]), .bus(if2));

    assign if0.rx_valid = rx_valid_v[0];
    assign if0.rx_data  = rx_data_v[0];
    assign if0.hold     = hold_v[0];
    assign if0.clear    = clear_v[0];
    assign if1.rx_valid = rx_valid_v[1];
    assign if1.rx_data  = rx_data_v[1];
    assign if1.hold     = hold_v[1];
    assign if1.clear    = clear_v[1];
    assign if2.rx_valid = rx_valid_v[2];
    assign if2.rx_data  = rx_data_v[2];
    assign if2.hold     = hold_v[2];
    assign if2.clear    = clear_v[2];

    assign an_w[0]   = {4'hF, if0.an};
    assign an_w[1]   = {4'hF, if1.an};
    assign an_w[2]   = if2.an;
    assign out_w[0]  = if0.out;
    assign out_w[1]  = if1.out;
    assign out_w[2]  = if2.out;
    assign dsel_w[0] = {1'b0, if0.digit_sel};
    assign dsel_w[1] = {1'b0, if1.digit_sel};
    assign dsel_w[2] = if2.digit_sel;
    assign fs_w[0]   = if0.frame_start;
    assign fs_w[1]   = if1.frame_start;
    assign fs_w[2]   = if2.frame_start;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, k, $time, act, exp_v);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] an;
        logic [3:0] out;
        logic [2:0] dsel;
        logic       fs;
    } exp_t;

    exp_t expq[$];

    // Reference model: the digit history is an array of nibbles and the scan
    // position follows purely from the number of edges since reset release.
    int nib      [3][8];
    int cyc      [3];
    int snap_nib [3];
    bit snap_sup [3];
    int m_slot, m_pos, m_dig;
    exp_t me;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            me.k = k;
            if (rst_v[k]) begin
                cyc[k]      = 0;
                snap_nib[k] = 0;
                snap_sup[k] = 1'b0;
                for (int j = 0; j < 8; j++) nib[k][j] = 0;
                me.an   = 8'hFF;
                me.out  = 4'h0;
                me.dsel = 3'(n_c[k] - 1);
                me.fs   = 1'b0;
            end else begin
                m_slot = bl_c[k] + dw_c[k];
                m_pos  = cyc[k] % m_slot;
                m_dig  = n_c[k] - 1 - ((cyc[k] / m_slot) % n_c[k]);
                if (m_pos == 0) begin
                    snap_nib[k] = nib[k][m_dig];
                    snap_sup[k] = (lz_c[k] != 0) && (m_dig != 0);
                    for (int j = m_dig; j < n_c[k]; j++)
                        if (nib[k][j] != 0) snap_sup[k] = 1'b0;
                end
                me.an = 8'hFF;
                if (m_pos >= bl_c[k] && !snap_sup[k]) me.an[m_dig] = 1'b0;
                me.out  = 4'(snap_nib[k]);
                me.dsel = 3'(m_dig);
                me.fs   = (m_pos == 0) && (m_dig == n_c[k] - 1);
                if (clear_v[k]) begin
                    for (int j = 0; j < 8; j++) nib[k][j] = 0;
                end else if (rx_valid_v[k] && !hold_v[k]) begin
                    for (int j = n_c[k] - 1; j >= 2; j--) nib[k][j] = nib[k][j-2];
                    nib[k][1] = int'(rx_data_v[k][7:4]);
                    nib[k][0] = int'(rx_data_v[k][3:0]);
                end
                cyc[k]++;
            end
            expq.push_back(me);
        end
    end

    // Monitor: every cycle each DUT presents its registered outputs; compare
    // them against the expectations queued by the model on the previous edge.
    exp_t mo;
    always @(negedge clk) begin
        while (expq.size() > 0) begin
            mo = expq.pop_front();
            if (rst_v[mo.k]) begin
                mo.an   = 8'hFF;
                mo.out  = 4'h0;
                mo.dsel = 3'(n_c[mo.k] - 1);
                mo.fs   = 1'b0;
            end
            chk("an",          mo.k, int'(an_w[mo.k]),   int'(mo.an));
            chk("out",         mo.k, int'(out_w[mo.k]),  int'(mo.out));
            chk("digit_sel",   mo.k, int'(dsel_w[mo.k]), int'(mo.dsel));
            chk("frame_start", mo.k, int'(fs_w[mo.k]),   int'(mo.fs));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int k, input logic [7:0] b);
        rx_valid_v[k] = 1'b1;
        rx_data_v[k]  = b;
        tick();
        rx_valid_v[k] = 1'b0;
    endtask

    int found;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_v[k]      = 1'b1;
            rx_valid_v[k] = 1'b0;
            rx_data_v[k]  = 8'h00;
            hold_v[k]     = 1'b0;
            clear_v[k]    = 1'b0;
        end
        idle(3);
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;

        // Free run with an empty buffer over two frames.
        idle(40);

        // Defaults: 3C then A5, then an update while digit 1 is lit.
        send(0, 8'h3C);
        idle(20);
        send(0, 8'hA5);
        idle(20);
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            if (if0.digit_sel == 2'd1 && if0.an[1] == 1'b0) found = 1;
            else tick();
        end
        chk("wait_d1_on", 0, found, 1);
        if (found != 0) send(0, 8'h7E);
        idle(36);

        // Clear beats a same-cycle strobe; hold freezes the buffer.
        clear_v[0]    = 1'b1;
        rx_valid_v[0] = 1'b1;
        rx_data_v[0]  = 8'hFF;
        tick();
        clear_v[0]    = 1'b0;
        rx_valid_v[0] = 1'b0;
        idle(20);
        send(0, 8'h9B);
        hold_v[0] = 1'b1;
        send(0, 8'h12);
        hold_v[0] = 1'b0;
        idle(20);

        // Leading-zero blanking: buffer 0x0005, then 0x0000.
        send(1, 8'h05);
        idle(34);
        clear_v[1] = 1'b1;
        tick();
        clear_v[1] = 1'b0;
        idle(34);
        send(1, 8'h10);
        idle(20);

        // Eight digits: back-to-back bytes, then a reset in mid-frame.
        for (int b = 1; b <= 4; b++) begin
            rx_valid_v[2] = 1'b1;
            rx_data_v[2]  = 8'(b * 8'h11);
            tick();
        end
        rx_valid_v[2] = 1'b0;
        idle(70);
        idle(13);
        rst_v[2] = 1'b1;
        #1;
        chk("async_an",  2, int'(an_w[2]),   8'hFF);
        chk("async_sel", 2, int'(dsel_w[2]), 7);
        idle(2);
        rst_v[2] = 1'b0;
        idle(40);

        // Randomised traffic on all three instances at once.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                rx_valid_v[k] = ($urandom_range(0, 2) == 0);
                rx_data_v[k]  = 8'($urandom_range(0, 255));
                hold_v[k]     = ($urandom_range(0, 4) == 0);
                clear_v[k]    = ($urandom_range(0, 24) == 0);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            rx_valid_v[k] = 1'b0;
            hold_v[k]     = 1'b0;
            clear_v[k]    = 1'b0;
        end
        idle(20);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
